// File: rtl/alu_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the shared ALU.
// The slave modport is the arbiter side; the master modport is the requester/ALU side.
interface alu_arbiter_if #(
    parameter int unsigned width = 32
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [width-1:0] req0_dataA;
    logic [width-1:0] req0_dataB;
    logic [3:0]       req0_func;
    logic [2:0]       req0_aluOp;

    logic             req1_valid;
    logic             req1_ready;
    logic [width-1:0] req1_dataA;
    logic [width-1:0] req1_dataB;
    logic [3:0]       req1_func;
    logic [2:0]       req1_aluOp;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [width-1:0] rsp_result;
    logic             rsp_branch;

    logic [width-1:0] alu_dataA;
    logic [width-1:0] alu_dataB;
    logic [3:0]       alu_func;
    logic [2:0]       alu_aluOp;
    logic [width-1:0] alu_result;
    logic             alu_branch;

    logic             busy;

    modport slave (
        input  req0_valid, req0_dataA, req0_dataB, req0_func, req0_aluOp,
        input  req1_valid, req1_dataA, req1_dataB, req1_func, req1_aluOp,
        input  rsp0_ready, rsp1_ready, alu_result, alu_branch,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_branch,
        output alu_dataA, alu_dataB, alu_func, alu_aluOp, busy
    );

    modport master (
        output req0_valid, req0_dataA, req0_dataB, req0_func, req0_aluOp,
        output req1_valid, req1_dataA, req1_dataB, req1_func, req1_aluOp,
        output rsp0_ready, rsp1_ready, alu_result, alu_branch,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_branch,
        input  alu_dataA, alu_dataB, alu_func, alu_aluOp, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, registered both ways.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win ties (requester 1 may starve).
module alu_arbiter #(
    parameter int unsigned width = 32
) (
    input  logic         clock,
    input  logic         resetn,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic [width-1:0] data_a_q, data_b_q, result_q;
    logic [3:0]       func_q;
    logic [2:0]       alu_op_q;
    logic             branch_q;

    logic             win_valid;
    logic             win_sel;
    logic             accept;
    logic             rsp_done;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_grant_q;
`endif

    always_comb begin
        win_valid = bus.req0_valid | bus.req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        win_sel = ~bus.req0_valid;
`else
        // On a tie the requester that was not served last goes next.
        if (bus.req0_valid && bus.req1_valid) begin
            win_sel = ~last_grant_q;
        end else begin
            win_sel = ~bus.req0_valid;
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        accept         = 1'b0;
        rsp_done       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    accept         = 1'b1;
                    grant_d        = win_sel;
                    state_d        = StExec;
                    bus.req0_ready = ~win_sel;
                    bus.req1_ready = win_sel;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                bus.rsp0_valid = ~grant_q;
                bus.rsp1_valid = grant_q;
                rsp_done       = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StIdle;
            grant_q  <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
            func_q   <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (accept) begin
                data_a_q <= win_sel ? bus.req1_dataA : bus.req0_dataA;
                data_b_q <= win_sel ? bus.req1_dataB : bus.req0_dataB;
                func_q   <= win_sel ? bus.req1_func  : bus.req0_func;
                alu_op_q <= win_sel ? bus.req1_aluOp : bus.req0_aluOp;
            end
            if (state_q == StExec) begin
                result_q <= bus.alu_result;
                branch_q <= bus.alu_branch;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_grant_q <= 1'b1;
        end else if (rsp_done) begin
            last_grant_q <= grant_q;
        end
    end
`endif

    always_comb begin
        bus.alu_dataA  = data_a_q;
        bus.alu_dataB  = data_b_q;
        bus.alu_func   = func_q;
        bus.alu_aluOp  = alu_op_q;
        bus.rsp_result = result_q;
        bus.rsp_branch = branch_q;
        bus.busy       = (state_q != StIdle);
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single transactions plus
// hand-written tie, backpressure and reset-in-response sequences.
module tb_alu_arbiter;
    localparam int unsigned W = 32;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    alu_arbiter_if #(.width(W)) bus ();

    alu_arbiter #(.width(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Reference ALU: op 0 add, 1 sub, 2 logic by func, else xor; branch by func.
    always_comb begin
        bus.alu_result = '0;
        bus.alu_branch = 1'b0;
        case (bus.alu_aluOp)
            3'd0: bus.alu_result = bus.alu_dataA + bus.alu_dataB;
            3'd1: bus.alu_result = bus.alu_dataA - bus.alu_dataB;
            3'd2: begin
                case (bus.alu_func)
                    4'd4:    bus.alu_result = bus.alu_dataA | bus.alu_dataB;
                    4'd7:    bus.alu_result = bus.alu_dataA & bus.alu_dataB;
                    default: bus.alu_result = bus.alu_dataA ^ bus.alu_dataB;
                endcase
            end
            default: bus.alu_result = bus.alu_dataA ^ bus.alu_dataB;
        endcase
        case (bus.alu_func)
            4'd0: bus.alu_branch = (bus.alu_dataA == bus.alu_dataB);
            4'd1: bus.alu_branch = (bus.alu_dataA != bus.alu_dataB);
            4'd4: bus.alu_branch = ($signed(bus.alu_dataA) < $signed(bus.alu_dataB));
            4'd5: bus.alu_branch = ($signed(bus.alu_dataA) >= $signed(bus.alu_dataB));
            4'd6: bus.alu_branch = (bus.alu_dataA < bus.alu_dataB);
            4'd7: bus.alu_branch = (bus.alu_dataA >= bus.alu_dataB);
            default: bus.alu_branch = 1'b0;
        endcase
    end

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  func;
        logic [2:0]  op;
        logic [31:0] res;
        logic        br;
    } vec_t;

    vec_t vecs [8];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic sel, input logic valid, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] f, input logic [2:0] op);
        if (sel) begin
            bus.req1_valid = valid;
            bus.req1_dataA = a;
            bus.req1_dataB = b;
            bus.req1_func  = f;
            bus.req1_aluOp = op;
        end else begin
            bus.req0_valid = valid;
            bus.req0_dataA = a;
            bus.req0_dataB = b;
            bus.req0_func  = f;
            bus.req0_aluOp = op;
        end
    endtask

    task automatic clear_inputs();
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0, '0, '0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    // One transaction from idle with the response taken immediately.
    task automatic run_vec(input vec_t v);
        set_req(v.sel, 1'b1, v.a, v.b, v.func, v.op);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
        check1("req_ready_win", v.sel ? bus.req1_ready : bus.req0_ready, 1'b1);
        check1("req_ready_other", v.sel ? bus.req0_ready : bus.req1_ready, 1'b0);
        tick();
        set_req(v.sel, 1'b0, v.a, v.b, v.func, v.op);
        check1("exec_rsp_valid", v.sel ? bus.rsp1_valid : bus.rsp0_valid, 1'b0);
        check1("exec_busy", bus.busy, 1'b1);
        check32("exec_alu_dataA", bus.alu_dataA, v.a);
        check32("exec_alu_dataB", bus.alu_dataB, v.b);
        tick();
        check1("resp_valid", v.sel ? bus.rsp1_valid : bus.rsp0_valid, 1'b1);
        check1("resp_other_valid", v.sel ? bus.rsp0_valid : bus.rsp1_valid, 1'b0);
        check32("resp_result", bus.rsp_result, v.res);
        check1("resp_branch", bus.rsp_branch, v.br);
        tick();
        check1("done_busy", bus.busy, 1'b0);
        check1("done_rsp_valid", v.sel ? bus.rsp1_valid : bus.rsp0_valid, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_sel;

        vecs[0] = '{1'b0, 32'd5, 32'd3, 4'd0, 3'd0, 32'd8, 1'b0};
        vecs[1] = '{1'b1, 32'd10, 32'd4, 4'd0, 3'd1, 32'd6, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_00F0, 32'h0000_000F, 4'd4, 3'd2, 32'h0000_00FF, 1'b0};
        vecs[3] = '{1'b1, 32'd2, 32'd7, 4'd4, 3'd3, 32'd5, 1'b1};
        vecs[4] = '{1'b0, 32'd9, 32'd9, 4'd1, 3'd3, 32'd0, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 3'd0, 32'd0, 1'b0};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'd1, 4'd4, 3'd1, 32'h7FFF_FFFF, 1'b1};
        vecs[7] = '{1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 4'd7, 3'd2, 32'd0, 1'b1};

        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        check1("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        check1("rst_req0_ready", bus.req0_ready, 1'b0);
        check1("rst_req1_ready", bus.req1_ready, 1'b0);
        check32("rst_result", bus.rsp_result, 32'd0);
        check1("rst_branch", bus.rsp_branch, 1'b0);
        check32("rst_alu_dataA", bus.alu_dataA, 32'd0);
        resetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both requesters continuously valid: alternation, or req0 always with fixed priority.
        pulse_reset();
        set_req(1'b0, 1'b1, 32'd10, 32'd4, 4'd0, 3'd1);
        set_req(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 4'd4, 3'd2);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_sel = 1'b0;
`else
            exp_sel = i[0];
`endif
            #1;
            check1("tie_req0_ready", bus.req0_ready, ~exp_sel);
            check1("tie_req1_ready", bus.req1_ready, exp_sel);
            tick();
            check1("tie_exec_req0_ready", bus.req0_ready, 1'b0);
            tick();
            check1("tie_rsp0_valid", bus.rsp0_valid, ~exp_sel);
            check1("tie_rsp1_valid", bus.rsp1_valid, exp_sel);
            check32("tie_result", bus.rsp_result, exp_sel ? 32'h0000_00FF : 32'd6);
            tick();
        end

        // Response backpressure on requester 1 while requester 0 waits.
        pulse_reset();
        set_req(1'b1, 1'b1, 32'd2, 32'd7, 4'd4, 3'd3);
        #1;
        check1("bp_req1_ready", bus.req1_ready, 1'b1);
        tick();
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        set_req(1'b0, 1'b1, 32'd1, 32'd1, 4'd0, 3'd0);
        #1;
        check1("bp_exec_req0_ready", bus.req0_ready, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check1("bp_rsp1_valid", bus.rsp1_valid, 1'b1);
            check32("bp_result", bus.rsp_result, 32'd5);
            check1("bp_branch", bus.rsp_branch, 1'b1);
            check1("bp_req0_ready", bus.req0_ready, 1'b0);
            if (k == 4) bus.rsp1_ready = 1'b1;
            tick();
        end
        check1("bp_after_rsp1_valid", bus.rsp1_valid, 1'b0);
        check1("bp_after_req0_ready", bus.req0_ready, 1'b1);
        bus.rsp0_ready = 1'b1;
        tick();
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        tick();
        check1("bp_rsp0_valid", bus.rsp0_valid, 1'b1);
        check32("bp_rsp0_result", bus.rsp_result, 32'd2);
        tick();
        check1("bp_done_busy", bus.busy, 1'b0);

        // Reset while a response is pending discards it.
        pulse_reset();
        set_req(1'b0, 1'b1, 32'd5, 32'd3, 4'd0, 3'd0);
        #1;
        check1("rr_req0_ready", bus.req0_ready, 1'b1);
        tick();
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        tick();
        check1("rr_rsp0_valid_before", bus.rsp0_valid, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check1("rr_rsp0_valid_after", bus.rsp0_valid, 1'b0);
        check1("rr_busy_after", bus.busy, 1'b0);
        check32("rr_result_after", bus.rsp_result, 32'd0);
        bus.rsp0_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check1("rr_no_late_rsp", bus.rsp0_valid, 1'b0);
            check1("rr_idle_busy", bus.busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters: requester 0 is the execute stage, requester 1 is the address/branch helper.
- The ALU is the combinational unit with ports dataA, dataB, func, aluOp, aluResult and branchFromAlu.
- Round-robin arbitration with a valid/ready handshake on both request and response.
- Operands and results are registered, so ALU timing is isolated from both requesters.
- Sits between the decode/execute logic and the single ALU instance.

Parameters:
- width, 32, datapath width of operands and result.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_dataA / req0_dataB  input  width  requester 0 operands.
- req0_func  input  4  requester 0 function code.
- req0_aluOp  input  3  requester 0 ALU op class.
- req1_valid, req1_ready, req1_dataA, req1_dataB, req1_func, req1_aluOp: same as requester 0, for requester 1.
- rsp0_valid  output  1  result held for requester 0.
- rsp1_valid  output  1  result held for requester 1.
- rsp0_ready / rsp1_ready  input  1  requester takes its result.
- rsp_result  output  width  registered ALU result, shared by both requesters.
- rsp_branch  output  1  registered branch flag, shared by both requesters.
- alu_dataA / alu_dataB  output  width  operands to the ALU.
- alu_func  output  4  function code to the ALU.
- alu_aluOp  output  3  op class to the ALU.
- alu_result  input  width  ALU aluResult.
- alu_branch  input  1  ALU branchFromAlu.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE; lastGrant=1, so requester 0 wins the first tie; grant=0.
  - Operand registers, rsp_result and rsp_branch = 0.
  - All valid/ready outputs and busy = 0.
- Alu_* outputs are driven directly from the operand registers at all times.
- IDLE:
  - Winner selection:
    - Only one reqN_valid high: that requester wins.
    - Both high: the requester that is not lastGrant wins.
  - reqN_ready is combinational: it is 1 only for the winner, only in IDLE.
  - On a win: latch the winner's dataA, dataB, func and aluOp; set grant=N; go to EXEC.
  - Neither valid: stay in IDLE.
- EXEC (1 cycle):
  - Capture alu_result into rsp_result and alu_branch into rsp_branch.
  - Go to RESP.
- RESP:
  - rsp<grant>_valid=1; the other rsp valid is 0.
  - rsp_result and rsp_branch are held stable until the handshake.
  - On rsp<grant>_ready=1: lastGrant=grant; go to IDLE.
  - No new request is accepted in this same cycle.
- Latency:
  - Request accepted in cycle T; rspN_valid rises in cycle T+2.
  - Minimum issue interval is 3 cycles when rspN_ready is held high.
- Req ready is 0 in EXEC and RESP; requests presented then are held off and not lost.
- Requester dropping reqN_valid while not ready: no effect.
- rspN_ready high before rspN_valid: ignored, no effect.
- A single active requester is granted back-to-back; lastGrant only biases ties.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is produced, and all reset values apply.
- Widths: no arithmetic in this block; operands and results pass unmodified.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined:
  - Requester 0 always wins a tie.
  - lastGrant is not used, and requester 1 can starve.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then req0 only:
  - Stimulus: dataA=5, dataB=3, aluOp=000, rsp0_ready=1.
  - Required: req0_ready in cycle T, rsp0_valid in T+2, rsp_result=8; busy low again in T+3.
- Simultaneous requests after reset:
  - Stimulus: req0 sub (aluOp=001, 10−4); req1 or (aluOp=010, func=4, 0xF0|0x0F).
  - Required: req0 served first with result 6, then req1 with 0xFF.
  - Then re-assert both: req1 (not lastGrant) wins again next → after the req1 grant, lastGrant=1, so req0 wins the next tie (alternation).
- Response backpressure:
  - Stimulus: rsp1_ready held 0 for 5 cycles, req0_valid high throughout.
  - Required: rsp1_valid and rsp_result stable; req0_ready stays 0; req0 is granted in the cycle after the rsp1 handshake.
- Branch path:
  - Stimulus: func=4, dataA=2, dataB=7.
  - Required: rsp_branch=1.
  - Stimulus: func=1, dataA=dataB=9.
  - Required: rsp_branch=0.
- Reset in RESP:
  - Stimulus: resetn=0 for 1 cycle while rsp0_valid=1.
  - Required: rsp0_valid=0, busy=0 next cycle; no response is ever delivered for that operation.
- With ALU_ARB_FIXED_PRIO_EN:
  - Stimulus: both requesters continuously valid for 4 transactions.
  - Required: req0 is granted every time.
